// File: rtl/mem_stage_ctrl_pkg.sv
// Shared constants for the memory stage: FSM state encoding and default widths.
// The execute-stage consumer decodes the same state values.
package mem_stage_ctrl_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int DATA_W_DEF  = 16;
    localparam int TIMEOUT_DEF = 15;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        REQ  = ST_REQ,
        WAIT = ST_WAIT,
        RESP = ST_RESP
    } memState_t;

endpackage

// File: rtl/dff.sv
// Codebase register cell: W-bit flop with synchronous active-high clear.
module dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else     q <= d;
    end

endmodule

// File: rtl/mem_wait_timer.sv
// Counts WAIT cycles; `expired` is high once the count has reached TIMEOUT.
module mem_wait_timer
    import mem_stage_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam logic [3:0] LIMIT = TIMEOUT[3:0];

    logic       rstHi;
    logic [3:0] count;
    logic [3:0] countD;

    assign rstHi = ~rst;

    always_comb begin
        countD = count;
        if (clr)      countD = '0;
        else if (inc) countD = count + 4'd1;
    end

    dff #(.W(4)) uCount (.clk(clk), .rst(rstHi), .d(countD), .q(count));

    assign expired = (count == LIMIT);

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues one memory request per load/store, stalls the
// pipeline until completion, then pulses the result toward write-back.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memEn,
    input  logic              memWrt,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wrData,
    input  logic              flushPipe,
    output logic              memStall,
    output logic [DATA_W-1:0] rdData,
    output logic              rdValid,
    output logic              wrDone,
    output logic              err,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_busy,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        dbgState
);

    logic              rstHi;
    logic [1:0]        stateQ;
    memState_t         state;
    memState_t         nextState;
    logic              start;
    logic              unalign;
    logic [ADDR_W-1:0] addrQ;
    logic [DATA_W-1:0] wdataQ;
    logic              wrtQ;
    logic [DATA_W-1:0] rdataQ;
    logic [DATA_W-1:0] rdataD;
    logic              errFlagQ;
    logic              errFlagD;
    logic              unalErrQ;
    logic              timerClr;
    logic              timerInc;
    logic              timerExpired;

    assign rstHi    = ~rst;
    assign state    = memState_t'(stateQ);
    assign dbgState = stateQ;

    // Only IDLE accepts; RESP ignores memEn since it still belongs to the completing op.
    assign start   = (state == IDLE) & memEn & ~flushPipe & ~addr[0];
    assign unalign = (state == IDLE) & memEn & ~flushPipe &  addr[0];

    // Memory handshake: mem_rd/mem_wr is a request valid, ~mem_busy is ready.
    // While busy the strobe, mem_addr and mem_wdata stay stable; the request is
    // taken on the first cycle with the strobe high and mem_busy low.
    always_comb begin
        nextState = state;
        memStall  = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        timerClr  = 1'b0;
        timerInc  = 1'b0;
        errFlagD  = 1'b0;
        rdataD    = rdataQ;
        case (state)
            IDLE: begin
                memStall = start;
                if (start) nextState = REQ;
            end
            REQ: begin
                memStall = 1'b1;
                mem_rd   = ~wrtQ;
                mem_wr   = wrtQ;
                if (!mem_busy) begin
                    nextState = WAIT;
                    timerClr  = 1'b1;
                end
            end
            WAIT: begin
                memStall = 1'b1;
                if (mem_done) begin
                    nextState = RESP;
                    if (!wrtQ) rdataD = mem_rdata;
                end else if (timerExpired) begin
                    nextState = RESP;
                    errFlagD  = 1'b1;
                end else begin
                    timerInc = 1'b1;
                end
            end
            RESP: begin
                errFlagD  = errFlagQ;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    dff #(.W(2))      uState  (.clk(clk), .rst(rstHi), .d(nextState),               .q(stateQ));
    dff #(.W(ADDR_W)) uAddr   (.clk(clk), .rst(rstHi), .d(start ? addr : addrQ),    .q(addrQ));
    dff #(.W(DATA_W)) uWdata  (.clk(clk), .rst(rstHi), .d(start ? wrData : wdataQ), .q(wdataQ));
    dff #(.W(1))      uWrt    (.clk(clk), .rst(rstHi), .d(start ? memWrt : wrtQ),   .q(wrtQ));
    dff #(.W(DATA_W)) uRdata  (.clk(clk), .rst(rstHi), .d(rdataD),                  .q(rdataQ));
    dff #(.W(1))      uErrFlg (.clk(clk), .rst(rstHi), .d(errFlagD),                .q(errFlagQ));
    dff #(.W(1))      uUnal   (.clk(clk), .rst(rstHi), .d(unalign),                 .q(unalErrQ));

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) uTimer (
        .clk(clk),
        .rst(rst),
        .clr(timerClr),
        .inc(timerInc),
        .expired(timerExpired)
    );

    assign mem_addr  = (state == REQ) ? addrQ  : '0;
    assign mem_wdata = (state == REQ) ? wdataQ : '0;
    assign rdData    = rdataQ;
    assign rdValid   = (state == RESP) & ~wrtQ & ~errFlagQ;
    assign wrDone    = (state == RESP) &  wrtQ & ~errFlagQ;
    assign err       = ((state == RESP) & errFlagQ) | unalErrQ;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: per-access cycle counts, handshake stability,
// error paths, flush and reset behaviour, plus a load-data scoreboard.
module tb_mem_stage_ctrl;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        memEn = 1'b0;
    logic        memWrt = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wrData = '0;
    logic        flushPipe = 1'b0;
    logic        memStall;
    logic [15:0] rdData;
    logic        rdValid;
    logic        wrDone;
    logic        err;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_busy = 1'b0;
    logic        mem_done = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [1:0]  dbgState;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];

    mem_stage_ctrl #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .memEn(memEn), .memWrt(memWrt), .addr(addr),
        .wrData(wrData), .flushPipe(flushPipe), .memStall(memStall),
        .rdData(rdData), .rdValid(rdValid), .wrDone(wrDone), .err(err),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_busy(mem_busy), .mem_done(mem_done),
        .mem_rdata(mem_rdata), .dbgState(dbgState)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every rdValid must match the oldest expected load result.
    always @(negedge clk) begin
        if (rdValid) begin
            if (exp_q.size() > 0) check("rd_data", 32'(rdData), 32'(exp_q.pop_front()));
            else                  check("rd_spurious", 32'(rdValid), 0);
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkQuiet(input string tag);
        check({tag, "_state"}, 32'(dbgState), 32'(S_IDLE));
        check({tag, "_outs"},
              32'({memStall, rdValid, wrDone, err, mem_rd, mem_wr}), 0);
        check({tag, "_bus"}, 32'({mem_addr, mem_wdata}), 0);
    endtask

    // Drives one access, responding as a memory with busyN busy cycles in REQ and
    // waitN not-done cycles in WAIT. Returns what was observed per cycle.
    task automatic doAccess(
        input  logic        wrt,
        input  logic [15:0] a,
        input  logic [15:0] d,
        input  int          busyN,
        input  int          waitN,
        input  logic [15:0] rdat,
        input  logic        flushWait,
        output int          stallN,
        output int          strobeN,
        output int          respLat,
        output logic        sawRd,
        output logic        sawWr,
        output logic        gotRdv,
        output logic        gotWrd,
        output logic        gotErr,
        output logic        reqOk
    );
        int   busyCnt = 0;
        int   waitCnt = 0;
        int   waitStart = -1;
        logic done = 1'b0;
        stallN = 0; strobeN = 0; respLat = -1;
        sawRd = 1'b0; sawWr = 1'b0; gotRdv = 1'b0; gotWrd = 1'b0; gotErr = 1'b0;
        reqOk = 1'b1;
        memEn = 1'b1; memWrt = wrt; addr = a; wrData = d;
        for (int k = 0; k < 40 && !done; k++) begin
            mem_busy  = (dbgState == S_REQ) && (busyCnt < busyN);
            mem_done  = (dbgState == S_WAIT) && (waitCnt == waitN);
            mem_rdata = mem_done ? rdat : 16'hDEAD;
            flushPipe = flushWait && (dbgState == S_WAIT);
            @(negedge clk);
            if (memStall) stallN++;
            if (mem_rd || mem_wr) begin
                strobeN++;
                if (mem_addr !== a || (wrt && mem_wdata !== d)) reqOk = 1'b0;
            end
            sawRd = sawRd | mem_rd;
            sawWr = sawWr | mem_wr;
            if (dbgState == S_WAIT && waitStart < 0) waitStart = k;
            if (dbgState == S_REQ && mem_busy) busyCnt++;
            if (dbgState == S_WAIT) waitCnt++;
            if (dbgState == S_RESP) begin
                gotRdv = rdValid; gotWrd = wrDone; gotErr = err;
                respLat = k - waitStart;
                done = 1'b1;
            end
            nextCycle();
        end
        memEn = 1'b0; flushPipe = 1'b0; mem_done = 1'b0; mem_busy = 1'b0;
        check("resp_reached", 32'(done), 1);
    endtask

    int   stallN, strobeN, respLat;
    logic sawRd, sawWr, gotRdv, gotWrd, gotErr, reqOk;

    initial begin
        // Reset
        rst = 1'b0;
        repeat (3) nextCycle();
        rst = 1'b1;
        @(negedge clk);
        checkQuiet("reset");
        check("reset_rddata", 32'(rdData), 0);
        nextCycle();

        // Minimum-latency load
        exp_q.push_back(16'hBEEF);
        doAccess(1'b0, 16'h0010, 16'h0000, 0, 0, 16'hBEEF, 1'b0,
                 stallN, strobeN, respLat, sawRd, sawWr, gotRdv, gotWrd, gotErr, reqOk);
        check("ld_stall", 32'(stallN), 3);
        check("ld_rd_cycles", 32'(strobeN), 1);
        check("ld_no_wr", 32'(sawWr), 0);
        check("ld_req_addr", 32'(reqOk), 1);
        check("ld_rdvalid", 32'({gotRdv, gotWrd, gotErr}), 32'(3'b100));
        check("ld_resp_lat", 32'(respLat), 1);
        @(negedge clk);
        check("ld_idle_after", 32'(dbgState), 32'(S_IDLE));
        check("ld_rddata_hold", 32'(rdData), 32'(16'hBEEF));
        nextCycle();

        // Store with two busy cycles
        doAccess(1'b1, 16'h0020, 16'h1234, 2, 0, 16'h0000, 1'b0,
                 stallN, strobeN, respLat, sawRd, sawWr, gotRdv, gotWrd, gotErr, reqOk);
        check("st_stall", 32'(stallN), 5);
        check("st_wr_cycles", 32'(strobeN), 3);
        check("st_no_rd", 32'(sawRd), 0);
        check("st_req_stable", 32'(reqOk), 1);
        check("st_wrdone", 32'({gotRdv, gotWrd, gotErr}), 32'(3'b010));
        check("st_rddata_kept", 32'(rdData), 32'(16'hBEEF));

        // Unaligned load: no request, registered err pulse
        memEn = 1'b1; memWrt = 1'b0; addr = 16'h0021;
        @(negedge clk);
        check("ua_no_stall", 32'(memStall), 0);
        check("ua_no_rd", 32'(mem_rd), 0);
        check("ua_err_not_yet", 32'(err), 0);
        nextCycle();
        memEn = 1'b0;
        @(negedge clk);
        check("ua_err_pulse", 32'(err), 1);
        check("ua_state", 32'(dbgState), 32'(S_IDLE));
        check("ua_no_rd2", 32'({mem_rd, memStall}), 0);
        nextCycle();
        @(negedge clk);
        check("ua_err_drop", 32'(err), 0);
        nextCycle();

        // Timeout: mem_done never comes
        doAccess(1'b0, 16'h0050, 16'h0000, 0, 1000, 16'h0000, 1'b0,
                 stallN, strobeN, respLat, sawRd, sawWr, gotRdv, gotWrd, gotErr, reqOk);
        check("to_resp_lat", 32'(respLat), 16);
        check("to_stall", 32'(stallN), 18);
        check("to_err", 32'({gotRdv, gotWrd, gotErr}), 32'(3'b001));
        @(negedge clk);
        check("to_idle", 32'(dbgState), 32'(S_IDLE));
        check("to_err_drop", 32'({err, rdValid}), 0);
        nextCycle();

        // Flush in IDLE suppresses the request
        memEn = 1'b1; memWrt = 1'b1; addr = 16'h0030; flushPipe = 1'b1;
        @(negedge clk);
        check("fl_idle_stall", 32'(memStall), 0);
        nextCycle();
        memEn = 1'b0; flushPipe = 1'b0;
        @(negedge clk);
        checkQuiet("fl_idle");
        nextCycle();

        // Flush during WAIT does not abandon the load
        exp_q.push_back(16'hCAFE);
        doAccess(1'b0, 16'h0060, 16'h0000, 0, 2, 16'hCAFE, 1'b1,
                 stallN, strobeN, respLat, sawRd, sawWr, gotRdv, gotWrd, gotErr, reqOk);
        check("fw_rdvalid", 32'({gotRdv, gotWrd, gotErr}), 32'(3'b100));
        check("fw_stall", 32'(stallN), 5);

        // Reset while in WAIT
        memEn = 1'b1; memWrt = 1'b1; addr = 16'h0040; wrData = 16'h7777;
        nextCycle();
        memEn = 1'b0;
        nextCycle();
        @(negedge clk);
        check("rw_in_wait", 32'(dbgState), 32'(S_WAIT));
        nextCycle();
        rst = 1'b0;
        nextCycle();
        @(negedge clk);
        checkQuiet("rw_reset");
        check("rw_rddata", 32'(rdData), 0);
        nextCycle();
        rst = 1'b1;
        nextCycle();

        exp_q.push_back(16'h5A5A);
        doAccess(1'b0, 16'h0070, 16'h0000, 0, 0, 16'h5A5A, 1'b0,
                 stallN, strobeN, respLat, sawRd, sawWr, gotRdv, gotWrd, gotErr, reqOk);
        check("rw_ld_stall", 32'(stallN), 3);
        check("rw_ld_rdvalid", 32'({gotRdv, gotWrd, gotErr}), 32'(3'b100));
        check("rw_ld_addr", 32'(reqOk), 1);

        repeat (2) nextCycle();
        check("sb_drain", 32'(exp_q.size()), 0);

        // Final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
